// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bus master: FSM state encoding, GPIO slave
// address map and transfer size constants.
package gpio_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_CHECK  = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam logic [2:0] IN_A  = 3'b000;
    localparam logic [2:0] IN_B  = 3'b001;
    localparam logic [2:0] IN_C  = 3'b010;
    localparam logic [2:0] IN_D  = 3'b011;
    localparam logic [2:0] OUT_A = 3'b100;
    localparam logic [2:0] OUT_B = 3'b101;
    localparam logic [2:0] OUT_C = 3'b110;
    localparam logic [2:0] OUT_D = 3'b111;

    localparam logic [1:0] SIZE_BYTE = 2'b00;

    // Output ports live in the upper half of the address map.
    function automatic logic is_out_port(input logic [2:0] addr);
        return addr[2];
    endfunction

endpackage

// File: rtl/gpio_bus_master_if.sv
// Command/response channel plus GPIO slave-port signals for gpio_bus_master.
// The master modport is the bus master's view; slave is the environment's view.
interface gpio_bus_master_if #(
    parameter int GPIO_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [2:0]            cmd_addr;
    logic [GPIO_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [GPIO_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  err_sticky;

    logic                  en;
    logic                  we;
    logic                  re;
    logic [2:0]            Addr;
    logic [1:0]            size;
    logic [31:0]           wd_data;
    logic [31:0]           rd_data;
    logic                  done;
    logic                  check;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  rd_data, done, check,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_sticky,
        output en, we, re, Addr, size, wd_data
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output rd_data, done, check,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_sticky,
        input  en, we, re, Addr, size, wd_data
    );

endinterface

// File: rtl/gpio_timeout_ctr.sv
// Down-counter that flags expiry after LIMIT consecutive ticks since load.
// Used by gpio_bus_master only when GPIO_MASTER_TIMEOUT_EN is defined.
module gpio_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic tick,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = CW'(LIMIT);
        end else if (clear) begin
            count_next = '0;
        end else if (tick && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expiry fires on the tick that would take the count from one to zero.
    assign expire = tick && (count_reg == CW'(1));

endmodule

// File: rtl/gpio_bus_master.sv
// Sequences one GPIO slave access per command and returns read data and the
// newly raised slave error. Optional ACCESS timeout: GPIO_MASTER_TIMEOUT_EN.
module gpio_bus_master
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    gpio_bus_master_if.master  bus
);

    state_t                state_reg;
    state_t                state_next;

    logic                  we_reg;
    logic [2:0]            addr_reg;
    logic [GPIO_WIDTH-1:0] wdata_reg;
    logic                  first_reg;
    logic                  chk_prev_reg;

    logic [GPIO_WIDTH-1:0] rdata_reg;
    logic                  err_reg;
    logic                  sticky_reg;

    logic                  cmd_fire;
    logic                  in_access;
    logic                  in_resp;
    logic                  err_next;
    logic                  expire;
    logic [GPIO_WIDTH-1:0] rd_byte;
    logic [31:0]           wd_ext;

    assign in_access = (state_reg == ST_ACCESS);
    assign in_resp   = (state_reg == ST_RESP);
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign err_next  = bus.check && !chk_prev_reg;
    assign rd_byte   = bus.rd_data[GPIO_WIDTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_wd_ext
            if (gi < GPIO_WIDTH) begin : g_data
                assign wd_ext[gi] = wdata_reg[gi];
            end else begin : g_zero
                assign wd_ext[gi] = 1'b0;
            end
        end
        if (GPIO_WIDTH < 32) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^bus.rd_data[31:GPIO_WIDTH];
        end
    endgenerate

`ifdef GPIO_MASTER_TIMEOUT_EN
    logic timeout_reg;

    gpio_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (cmd_fire),
        .clear  (in_access && bus.done),
        .tick   (in_access && !bus.done),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else if (cmd_fire) begin
            timeout_reg <= 1'b0;
        end else if (in_access && !bus.done && expire) begin
            timeout_reg <= 1'b1;
        end
    end

    assign bus.rsp_timeout = in_resp && timeout_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire          = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (cmd_fire) state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.done) begin
                    state_next = ST_CHECK;
                end else if (expire) begin
                    state_next = ST_RESP;
                end
            end
            ST_CHECK:  state_next = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            first_reg    <= 1'b0;
            chk_prev_reg <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            sticky_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        we_reg    <= bus.cmd_we;
                        addr_reg  <= bus.cmd_addr;
                        wdata_reg <= bus.cmd_wdata;
                        first_reg <= 1'b1;
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    first_reg <= 1'b0;
                    // The slave flag is sticky, so only a rise across this
                    // access counts as an error caused by it.
                    if (first_reg) begin
                        chk_prev_reg <= bus.check;
                    end
                    if (bus.done) begin
                        rdata_reg <= we_reg ? '0 : rd_byte;
                    end else if (expire) begin
                        rdata_reg  <= '0;
                        err_reg    <= 1'b1;
                        sticky_reg <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_reg <= err_next;
                    if (err_next) begin
                        sticky_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (state_reg == ST_IDLE) && !rst;

    assign bus.en         = in_access;
    assign bus.we         = in_access && we_reg;
    assign bus.re         = in_access && !we_reg;
    assign bus.Addr       = in_access ? addr_reg : 3'b000;
    assign bus.size       = SIZE_BYTE;
    assign bus.wd_data    = in_access ? wd_ext : 32'h0;

    assign bus.rsp_valid  = in_resp;
    assign bus.rsp_rdata  = in_resp ? rdata_reg : '0;
    assign bus.rsp_err    = in_resp && err_reg;
    assign bus.err_sticky = sticky_reg;

endmodule
